// File: rtl/fifo_pkg.sv
// Shared types and constants for the synchronous FIFO slice.
//   ptr_w(depth)     : pointer width (address bits plus one wrap bit)
//   fifo_status_t    : registered status flags carried as one word
//   FIFO_DEF_*       : default geometry (8-bit words, 32 entries)
package fifo_pkg;

    localparam int FIFO_DEF_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH = 32;

    // Pointer width: address bits plus a wrap bit that separates full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    localparam fifo_status_t FIFO_STATUS_RST = '{
        empty:     1'b1,
        full:      1'b0,
        overflow:  1'b0,
        underflow: 1'b0
    };

endpackage

// File: rtl/fifo_sync_ctrl_if.sv
// Streaming interface between a producer/consumer pair and fifo_sync_ctrl.
//   master : producer/consumer side, drives wr_en/data_in/rd_en
//   slave  : FIFO side, drives data_out, empty, full, count, overflow, underflow
// With FIFO_ALMOST_FLAGS_EN defined the slave also drives almost_full and
// almost_empty; without it those signals do not exist.
interface fifo_sync_ctrl_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_DEF_WIDTH,
    parameter int DEPTH = FIFO_DEF_DEPTH
);

    logic                      wr_en;
    logic [WIDTH-1:0]          data_in;
    logic                      rd_en;
    logic [WIDTH-1:0]          data_out;
    logic                      empty;
    logic                      full;
    logic [ptr_w(DEPTH)-1:0]   count;
    logic                      overflow;
    logic                      underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic                      almost_full;
    logic                      almost_empty;
`endif

    modport master (
        output wr_en, data_in, rd_en,
`ifdef FIFO_ALMOST_FLAGS_EN
        input  almost_full, almost_empty,
`endif
        input  data_out, empty, full, count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en,
`ifdef FIFO_ALMOST_FLAGS_EN
        output almost_full, almost_empty,
`endif
        output data_out, empty, full, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFO: one write port, one registered read port.
//   clk, rstN              : clock, async active-low reset (read register only)
//   wr_en_i/wr_addr_i/wr_data_i : write port
//   rd_en_i/rd_addr_i      : read request; rd_data_o updates one cycle later
//   rd_data_o              : registered read data, holds when rd_en_i is low
module fifo_ram #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto block/distributed RAM; a
    // reset loop over every entry would force it into flops.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read-before-write: when a full FIFO reads and writes the same slot, the
    // old (oldest) word is returned and the new word replaces it.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Parametrised single-clock FIFO controller: owns the pointers, occupancy
// count, status flags and one-cycle overflow/underflow pulses; storage lives
// in fifo_ram. Simultaneous read and write are accepted in one cycle.
//   clk   : rising-edge clock
//   rstN  : asynchronous active-low reset
//   bus   : fifo_sync_ctrl_if.slave (wr_en, data_in, rd_en in;
//           data_out, empty, full, count, overflow, underflow out)
// Optional feature macro FIFO_ALMOST_FLAGS_EN adds AF_LVL/AE_LVL parameters and
// the almost_full (count >= AF_LVL) / almost_empty (count <= AE_LVL) outputs.
module fifo_sync_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH  = FIFO_DEF_WIDTH,
`ifdef FIFO_ALMOST_FLAGS_EN
    parameter int AF_LVL = 28,
    parameter int AE_LVL = 4,
`endif
    parameter int DEPTH  = FIFO_DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rstN,
    fifo_sync_ctrl_if.slave   bus
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    if (WIDTH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_geometry
        $error("fifo_sync_ctrl: WIDTH must be >= 1 and DEPTH a power of two >= 4");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q,  count_d;
    fifo_status_t     status_q, status_d;
    logic             wr_acc,   rd_acc;
    logic [WIDTH-1:0] rd_data;

`ifdef FIFO_ALMOST_FLAGS_EN
    if (AF_LVL > DEPTH || AE_LVL >= AF_LVL) begin : g_bad_levels
        $error("fifo_sync_ctrl: need AF_LVL <= DEPTH and AE_LVL < AF_LVL");
    end

    localparam logic [PW-1:0] AF_CNT = PW'(AF_LVL);
    localparam logic [PW-1:0] AE_CNT = PW'(AE_LVL);

    logic almost_full_q, almost_empty_q;
`endif

    // NOTE: every signal gets a value on every path through always_comb
    // (status_d starts as a copy) so no latch is inferred.
    always_comb begin
        status_d = status_q;

        // A write to a full FIFO is still taken when a read frees a slot in
        // the same cycle; a read of an empty FIFO is never bypassed.
        wr_acc = bus.wr_en & (~status_q.full | bus.rd_en);
        rd_acc = bus.rd_en & ~status_q.empty;

        wr_ptr_d = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d = rd_ptr_q + PW'(rd_acc);
        count_d  = count_q + PW'(wr_acc) - PW'(rd_acc);

        // Flags come from next-state pointers so they line up with count.
        status_d.empty     = (wr_ptr_d == rd_ptr_d);
        status_d.full      = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                             (wr_ptr_d[AW] != rd_ptr_d[AW]);
        status_d.overflow  = bus.wr_en & ~wr_acc;
        status_d.underflow = bus.rd_en & ~rd_acc;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            status_q       <= FIFO_STATUS_RST;
`ifdef FIFO_ALMOST_FLAGS_EN
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
`endif
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            status_q       <= status_d;
`ifdef FIFO_ALMOST_FLAGS_EN
            almost_full_q  <= (count_d >= AF_CNT);
            almost_empty_q <= (count_d <= AE_CNT);
`endif
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .rstN      (rstN),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (bus.data_in),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_data)
    );

    assign bus.data_out  = rd_data;
    assign bus.empty     = status_q.empty;
    assign bus.full      = status_q.full;
    assign bus.count     = count_q;
    assign bus.overflow  = status_q.overflow;
    assign bus.underflow = status_q.underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Self-checking bench for fifo_sync_ctrl (WIDTH=8, DEPTH=32). A hand-written
// vector table covers the short corner cases; longer sequences (fill, overflow,
// drain, streaming across pointer wrap, async reset) are checked against a
// queue-based reference model plus hand-computed data order.
// Almost-flag checks (AF=28, AE=4) are active when FIFO_ALMOST_FLAGS_EN is defined.
module tb_fifo_sync_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
`ifdef FIFO_ALMOST_FLAGS_EN
    localparam int AF = 28;
    localparam int AE = 4;
`endif

    logic clk  = 1'b0;
    logic rstN = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] m_dout = '0;

    typedef struct {
        string            name;
        logic             wr;
        logic             rd;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] e_dout;
        int               e_cnt;
        logic             e_ovf;
        logic             e_unf;
    } vec_t;

    vec_t vecs [12];

    fifo_sync_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_sync_ctrl #(
        .WIDTH  (WIDTH),
`ifdef FIFO_ALMOST_FLAGS_EN
        .AF_LVL (AF),
        .AE_LVL (AE),
`endif
        .DEPTH  (DEPTH)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string name, input logic wr, input logic rd,
                                input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] e_dout,
                                input int e_cnt, input logic e_ovf, input logic e_unf);
        vec_t v;
        v.name = name; v.wr = wr; v.rd = rd; v.din = din;
        v.e_dout = e_dout; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [WIDTH-1:0] e_dout,
                              input int e_cnt, input logic e_ovf, input logic e_unf);
        check({tag, " data_out"},  32'(bus.data_out),  32'(e_dout));
        check({tag, " count"},     32'(bus.count),     32'(e_cnt));
        check({tag, " empty"},     32'(bus.empty),     32'(e_cnt == 0));
        check({tag, " full"},      32'(bus.full),      32'(e_cnt == DEPTH));
        check({tag, " overflow"},  32'(bus.overflow),  32'(e_ovf));
        check({tag, " underflow"}, 32'(bus.underflow), 32'(e_unf));
`ifdef FIFO_ALMOST_FLAGS_EN
        check({tag, " almost_full"},  32'(bus.almost_full),  32'(e_cnt >= AF));
        check({tag, " almost_empty"}, 32'(bus.almost_empty), 32'(e_cnt <= AE));
`endif
    endtask

    // Queue model: pop before push, so a full FIFO can read and write together.
    task automatic model_step(input logic wr, input logic rd, input logic [WIDTH-1:0] din,
                              output logic ovf, output logic unf);
        logic rd_ok, wr_ok;
        rd_ok = rd && (q.size() > 0);
        wr_ok = wr && ((q.size() < DEPTH) || rd);
        ovf   = wr && !wr_ok;
        unf   = rd && !rd_ok;
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(din);
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [WIDTH-1:0] din);
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input string tag, input logic wr, input logic rd,
                         input logic [WIDTH-1:0] din);
        logic ovf, unf;
        drive(wr, rd, din);
        model_step(wr, rd, din, ovf, unf);
        check_outs(tag, m_dout, q.size(), ovf, unf);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic ovf, unf;

        vecs[0]  = mk("v_idle",        1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0);
        vecs[1]  = mk("v_rd_empty",    1'b0, 1'b1, 8'h00, 8'h00, 0, 1'b0, 1'b1);
        vecs[2]  = mk("v_unf_clear",   1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0);
        vecs[3]  = mk("v_wr11",        1'b1, 1'b0, 8'h11, 8'h00, 1, 1'b0, 1'b0);
        vecs[4]  = mk("v_wr22",        1'b1, 1'b0, 8'h22, 8'h00, 2, 1'b0, 1'b0);
        vecs[5]  = mk("v_wrrd33",      1'b1, 1'b1, 8'h33, 8'h11, 2, 1'b0, 1'b0);
        vecs[6]  = mk("v_rd22",        1'b0, 1'b1, 8'h00, 8'h22, 1, 1'b0, 1'b0);
        vecs[7]  = mk("v_rd33",        1'b0, 1'b1, 8'h00, 8'h33, 0, 1'b0, 1'b0);
        vecs[8]  = mk("v_rd_empty2",   1'b0, 1'b1, 8'h00, 8'h33, 0, 1'b0, 1'b1);
        vecs[9]  = mk("v_wrrd_empty",  1'b1, 1'b1, 8'h5C, 8'h33, 1, 1'b0, 1'b1);
        vecs[10] = mk("v_rd5C",        1'b0, 1'b1, 8'h00, 8'h5C, 0, 1'b0, 1'b0);
        vecs[11] = mk("v_hold",        1'b0, 1'b0, 8'h00, 8'h5C, 0, 1'b0, 1'b0);

        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;

        // Reset, checked while still asserted
        #2 rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 8'h00, 0, 1'b0, 1'b0);
        @(negedge clk) rstN = 1'b1;

        // Table-driven corner cases
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].din);
            model_step(vecs[i].wr, vecs[i].rd, vecs[i].din, ovf, unf);
            check_outs(vecs[i].name, vecs[i].e_dout, vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_unf);
        end

        // Fill 0x00..0x1F
        for (int i = 0; i < DEPTH; i++)
            cycle($sformatf("fill%0d", i), 1'b1, 1'b0, 8'(i));

        // Write into a full FIFO: overflow pulse, count stays at DEPTH
        cycle("ovf_AA", 1'b1, 1'b0, 8'hAA);
        cycle("ovf_clear", 1'b0, 1'b0, 8'h00);

        // Drain: data in order, 0xAA never shows up
        for (int i = 0; i < DEPTH; i++) begin
            cycle($sformatf("drain%0d", i), 1'b0, 1'b1, 8'h00);
            check($sformatf("drain_order%0d", i), 32'(bus.data_out), i);
        end

        // Refill, then stream with simultaneous read/write across pointer wrap
        for (int i = 0; i < DEPTH; i++)
            cycle($sformatf("refill%0d", i), 1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 40; i++) begin
            cycle($sformatf("stream%0d", i), 1'b1, 1'b1, 8'(8'hC0 + i));
            check($sformatf("stream_order%0d", i), 32'(bus.data_out),
                  (i < DEPTH) ? 32'(8'h40 + i) : 32'(8'hC0 + i - DEPTH));
        end
        for (int i = 0; i < DEPTH; i++)
            cycle($sformatf("drain2_%0d", i), 1'b0, 1'b1, 8'h00);

        // Async reset with 10 words stored
        for (int i = 0; i < 10; i++)
            cycle($sformatf("pre_rst%0d", i), 1'b1, 1'b0, 8'(8'h90 + i));
        #2 rstN = 1'b0;
        #1;
        q.delete();
        m_dout = '0;
        check_outs("async_rst", 8'h00, 0, 1'b0, 1'b0);
        @(negedge clk) rstN = 1'b1;
        cycle("post_wr77", 1'b1, 1'b0, 8'h77);
        cycle("post_rd77", 1'b0, 1'b1, 8'h00);
        check("post_rst_data", 32'(bus.data_out), 32'h77);
        cycle("post_idle", 1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
